// File: rtl/tl_ul_mem_slave.sv
// TileLink-UL memory slave: splits Get/Put bursts into single-word accesses on a
// 1-cycle-latency synchronous SRAM and answers each request on channel D.
module tl_ul_mem_slave #(
  parameter int                DATA_W    = 64,
  parameter int                ADDR_W    = 64,
  parameter int                MEM_AW    = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_SIZE  = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          a_opcode_i,
  input  logic [2:0]          a_param_i,
  input  logic [2:0]          a_size_i,
  input  logic [3:0]          a_source_i,
  input  logic [ADDR_W-1:0]   a_address_i,
  input  logic [DATA_W/8-1:0] a_mask_i,
  input  logic [DATA_W-1:0]   a_data_i,
  input  logic                a_valid_i,
  output logic                a_ready_o,
  output logic [2:0]          d_opcode_o,
  output logic [1:0]          d_param_o,
  output logic [2:0]          d_size_o,
  output logic [3:0]          d_source_o,
  output logic [1:0]          d_sink_o,
  output logic                d_denied_o,
  output logic [DATA_W-1:0]   d_data_o,
  output logic                d_corrupt_o,
  output logic                d_valid_o,
  input  logic                d_ready_i,
  output logic                sram_req_o,
  output logic                sram_we_o,
  output logic [MEM_AW-1:0]   sram_addr_o,
  output logic [DATA_W/8-1:0] sram_be_o,
  output logic [DATA_W-1:0]   sram_wdata_o,
  input  logic [DATA_W-1:0]   sram_rdata_i
);
  localparam int         LG   = $clog2(DATA_W / 8);
  localparam int         BW   = 9;
  localparam logic [2:0] LG3  = 3'(LG);
  localparam logic [2:0] MAXS = 3'(MAX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_WR_BURST, S_WR_ACK, S_RD_REQ, S_RD_DATA} state_t;

  state_t              r_state, w_next;
  logic [BW-1:0]       r_k, r_beats;
  logic [MEM_AW-1:0]   r_idx;
  logic [2:0]          r_size;
  logic [3:0]          r_source;
  logic                r_denied, r_rd_first;
  logic [DATA_W-1:0]   r_rdata;

  logic [BW-1:0]       w_beats;
  logic [ADDR_W-1:0]   w_off, w_idx;
  logic [ADDR_W:0]     w_end;
  logic                w_is_put, w_is_get, w_bad_op, w_deny, w_fire, w_last;
  logic [MEM_AW-1:0]   w_addr_k;
  logic                w_unused;

  // Request decode of the head A beat: burst length, aligned word index, denial
  always_comb begin
    w_is_put = (a_opcode_i == 3'd0) || (a_opcode_i == 3'd1);
    w_is_get = (a_opcode_i == 3'd4);
    w_bad_op = !(w_is_put || w_is_get);
    w_beats  = (a_size_i <= LG3) ? BW'(1) : (BW'(1) << (a_size_i - LG3));
    w_off    = a_address_i - BASE_ADDR;
    w_idx    = (w_off >> LG) & ~ADDR_W'(w_beats - BW'(1));
    w_end    = {1'b0, w_idx} + (ADDR_W+1)'(w_beats);
    w_deny   = (a_address_i < BASE_ADDR) || (w_end > ((ADDR_W+1)'(1) << MEM_AW)) ||
               (a_size_i > MAXS) || w_bad_op;
  end

  assign w_unused  = ^{a_param_i, w_idx[ADDR_W-1:MEM_AW]};
  assign w_last    = (r_k == r_beats - BW'(1));
  assign w_addr_k  = r_idx + MEM_AW'(r_k);
  assign a_ready_o = !rst_i && ((r_state == S_IDLE) || (r_state == S_WR_BURST));
  assign w_fire    = a_valid_i && a_ready_o;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_fire) begin
        if (w_is_get)                          w_next = S_RD_REQ;
        else if (w_is_put && w_beats != BW'(1)) w_next = S_WR_BURST;
        else                                   w_next = S_WR_ACK;
      end
      S_WR_BURST: if (w_fire && w_last) w_next = S_WR_ACK;
      S_WR_ACK:   if (d_ready_i)        w_next = S_IDLE;
      S_RD_REQ:                         w_next = S_RD_DATA;
      S_RD_DATA:  if (d_ready_i)        w_next = w_last ? S_IDLE : S_RD_REQ;
      default:                          w_next = S_IDLE;
    endcase
  end

  always_comb begin
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_be_o    = '0;
    sram_wdata_o = '0;
    d_valid_o    = 1'b0;
    d_opcode_o   = 3'd0;
    d_param_o    = 2'd0;
    d_sink_o     = 2'd0;
    d_denied_o   = 1'b0;
    d_corrupt_o  = 1'b0;
    d_data_o     = '0;
    d_size_o     = 3'd0;
    d_source_o   = 4'd0;
    if (!rst_i) begin
      case (r_state)
        S_IDLE: if (w_fire && w_is_put && !w_deny) begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = w_idx[MEM_AW-1:0];
          sram_be_o    = a_mask_i;
          sram_wdata_o = a_data_i;
        end
        S_WR_BURST: if (w_fire && !r_denied) begin
          sram_req_o   = 1'b1;
          sram_we_o    = 1'b1;
          sram_addr_o  = w_addr_k;
          sram_be_o    = a_mask_i;
          sram_wdata_o = a_data_i;
        end
        S_WR_ACK: begin
          d_valid_o  = 1'b1;
          d_denied_o = r_denied;
        end
        S_RD_REQ: if (!r_denied) begin
          sram_req_o  = 1'b1;
          sram_addr_o = w_addr_k;
        end
        S_RD_DATA: begin
          d_valid_o   = 1'b1;
          d_opcode_o  = 3'd1;
          d_denied_o  = r_denied;
          d_corrupt_o = r_denied;
          // First cycle forwards the SRAM output; stalled cycles replay the held copy
          if (!r_denied) d_data_o = r_rd_first ? sram_rdata_i : r_rdata;
        end
        default: ;
      endcase
      if (d_valid_o) begin
        d_size_o   = r_size;
        d_source_o = r_source;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_k        <= '0;
      r_denied   <= 1'b0;
      r_rd_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_first <= (r_state == S_RD_REQ);
      case (r_state)
        S_IDLE: if (w_fire) begin
          r_denied <= w_deny;
          r_k      <= (w_is_put && w_beats != BW'(1)) ? BW'(1) : '0;
        end
        S_WR_BURST: if (w_fire)    r_k <= w_last ? '0 : r_k + BW'(1);
        S_RD_DATA:  if (d_ready_i) r_k <= w_last ? '0 : r_k + BW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (r_state == S_IDLE && w_fire) begin
      r_size   <= a_size_i;
      r_source <= a_source_i;
      r_idx    <= w_idx[MEM_AW-1:0];
      r_beats  <= w_bad_op ? BW'(1) : w_beats;
    end
    if (r_rd_first) r_rdata <= sram_rdata_i;
  end

endmodule

// File: tb/tb_tl_ul_mem_slave.sv
// Scoreboard bench for tl_ul_mem_slave: expected D beats are queued when requests
// are issued and compared as the DUT hands them out on channel D.
module tb_tl_ul_mem_slave;
  localparam int          DATA_W = 64;
  localparam int          MEM_AW = 12;
  localparam logic [63:0] BASE   = 64'h0000_0000_1000_0000;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [2:0]        a_opcode_i, a_param_i, a_size_i;
  logic [3:0]        a_source_i;
  logic [63:0]       a_address_i;
  logic [7:0]        a_mask_i;
  logic [63:0]       a_data_i;
  logic              a_valid_i, a_ready_o;
  logic [2:0]        d_opcode_o, d_size_o;
  logic [1:0]        d_param_o, d_sink_o;
  logic [3:0]        d_source_o;
  logic              d_denied_o, d_corrupt_o, d_valid_o, d_ready_i;
  logic [63:0]       d_data_o;
  logic              sram_req_o, sram_we_o;
  logic [MEM_AW-1:0] sram_addr_o;
  logic [7:0]        sram_be_o;
  logic [63:0]       sram_wdata_o, sram_rdata_i;

  typedef struct packed {
    logic [2:0]  opc;
    logic        den;
    logic        cor;
    logic [63:0] data;
    logic [2:0]  size;
    logic [3:0]  src;
  } exp_t;

  exp_t              q[$];
  logic [63:0]       ref_mem [0:4095];
  logic [63:0]       sram_mem [0:4095];
  int                checks = 0;
  int                errors = 0;
  int                sram_req_cnt = 0;
  int                last_wait;
  logic              last_req, last_we;
  logic [MEM_AW-1:0] last_addr;

  tl_ul_mem_slave #(.DATA_W(DATA_W), .ADDR_W(64), .MEM_AW(MEM_AW), .BASE_ADDR(BASE), .MAX_SIZE(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .a_opcode_i(a_opcode_i), .a_param_i(a_param_i), .a_size_i(a_size_i), .a_source_i(a_source_i),
    .a_address_i(a_address_i), .a_mask_i(a_mask_i), .a_data_i(a_data_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o),
    .d_opcode_o(d_opcode_o), .d_param_o(d_param_o), .d_size_o(d_size_o), .d_source_o(d_source_o),
    .d_sink_o(d_sink_o), .d_denied_o(d_denied_o), .d_data_o(d_data_o), .d_corrupt_o(d_corrupt_o),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
    .sram_be_o(sram_be_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous SRAM with one cycle of read latency
  always @(posedge clk_i) begin
    if (sram_req_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 8; b++)
          if (sram_be_o[b]) sram_mem[sram_addr_o][b*8 +: 8] <= sram_wdata_o[b*8 +: 8];
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  function automatic void model(input logic [2:0] opc, input logic [2:0] size, input logic [63:0] addr,
                                output int beats, output int idx, output bit deny);
    logic [63:0] i;
    beats = (size <= 3'd3) ? 1 : (1 << (size - 3'd3));
    i     = (addr - BASE) >> 3;
    i     = i & ~(64'(beats) - 64'd1);
    deny  = (addr < BASE) || (i + 64'(beats) > 64'd4096) || (size > 3'd6) ||
            !((opc == 3'd0) || (opc == 3'd1) || (opc == 3'd4));
    idx   = int'(i[11:0]);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sram_req_o) sram_req_cnt++;
      if (a_ready_o && d_valid_o) begin
        checks++; errors++;
        $display("FAIL a_ready_d_valid_overlap: both high at %0t, required never both", $time);
      end
      if (!rst_i && d_valid_o && d_ready_i) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL d_unexpected: got op=%0d src=%0d data=%h, required no response", d_opcode_o, d_source_o, d_data_o);
        end else begin
          e = q.pop_front();
          if (d_opcode_o !== e.opc || d_denied_o !== e.den || d_corrupt_o !== e.cor || d_data_o !== e.data ||
              d_size_o !== e.size || d_source_o !== e.src || d_param_o !== 2'd0 || d_sink_o !== 2'd0) begin
            errors++;
            $display("FAIL d_beat: got op=%0d den=%0b cor=%0b data=%h size=%0d src=%0d param=%0d sink=%0d, required op=%0d den=%0b cor=%0b data=%h size=%0d src=%0d",
                     d_opcode_o, d_denied_o, d_corrupt_o, d_data_o, d_size_o, d_source_o, d_param_o, d_sink_o,
                     e.opc, e.den, e.cor, e.data, e.size, e.src);
          end
        end
      end
    end
  endtask

  task automatic a_send(input logic [2:0] opc, input logic [2:0] size, input logic [3:0] src,
                        input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
    int n = 0;
    a_opcode_i = opc; a_size_i = size; a_source_i = src; a_address_i = addr;
    a_mask_i = mask; a_data_i = data; a_param_i = 3'd0; a_valid_i = 1'b1;
    @(negedge clk_i);
    while (!a_ready_o && n < 50) begin n++; @(negedge clk_i); end
    last_wait = n; last_req = sram_req_o; last_we = sram_we_o; last_addr = sram_addr_o;
    if (!a_ready_o) begin
      checks++; errors++;
      $display("FAIL a_timeout: a_ready_o=%0b after %0d cycles, required 1", a_ready_o, n);
    end
    @(posedge clk_i); #1;
    a_valid_i = 1'b0;
  endtask

  task automatic put_req(input logic [2:0] opc, input logic [2:0] size, input logic [3:0] src,
                         input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] base, input logic [63:0] step);
    int beats, idx; bit deny; exp_t e; logic [63:0] d, w;
    model(opc, size, addr, beats, idx, deny);
    if (!((opc == 3'd0) || (opc == 3'd1))) beats = 1;
    e.opc = 3'd0; e.den = deny; e.cor = 1'b0; e.data = 64'd0; e.size = size; e.src = src;
    q.push_back(e);
    for (int k = 0; k < beats; k++) begin
      d = base + step * 64'(k);
      if (!deny) begin
        w = ref_mem[idx + k];
        for (int b = 0; b < 8; b++) if (mask[b]) w[b*8 +: 8] = d[b*8 +: 8];
        ref_mem[idx + k] = w;
      end
      a_send(opc, size, src, addr, mask, d);
    end
  endtask

  task automatic get_req(input logic [2:0] size, input logic [3:0] src, input logic [63:0] addr);
    int beats, idx; bit deny; exp_t e;
    model(3'd4, size, addr, beats, idx, deny);
    for (int k = 0; k < beats; k++) begin
      e.opc = 3'd1; e.den = deny; e.cor = deny; e.size = size; e.src = src;
      e.data = deny ? 64'd0 : ref_mem[idx + k];
      q.push_back(e);
    end
    a_send(3'd4, size, src, addr, 8'hFF, 64'd0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q.size() != 0 || d_valid_o) && n < 300) begin @(posedge clk_i); #1; n++; end
    checks++;
    if (q.size() != 0 || d_valid_o) begin
      errors++;
      $display("FAIL %s_drain: %0d responses outstanding, d_valid_o=%0b, required 0 and 0", name, q.size(), d_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (a_ready_o !== 1'b0 || d_valid_o !== 1'b0 || sram_req_o !== 1'b0 || d_opcode_o !== 3'd0 ||
        d_data_o !== 64'd0 || d_source_o !== 4'd0 || d_denied_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: a_ready=%0b d_valid=%0b sram_req=%0b d_op=%0d d_data=%h, required all 0",
               a_ready_o, d_valid_o, sram_req_o, d_opcode_o, d_data_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    checks++;
    if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: a_ready=%0b d_valid=%0b, required 1 and 0", a_ready_o, d_valid_o);
    end
  endtask

  task automatic test_single();
    put_req(3'd0, 3'd3, 4'd5, BASE + 64'h40, 8'hFF, 64'hDEADBEEF_01234567, 64'd0);
    checks++;
    if (last_req !== 1'b1 || last_we !== 1'b1 || last_addr !== 12'd8) begin
      errors++;
      $display("FAIL single_write: req=%0b we=%0b addr=%0d, required 1 1 8", last_req, last_we, last_addr);
    end
    checks++;
    if (d_valid_o !== 1'b1 || d_opcode_o !== 3'd0 || d_source_o !== 4'd5) begin
      errors++;
      $display("FAIL single_ack_latency: d_valid=%0b op=%0d src=%0d at T+1, required 1 0 5", d_valid_o, d_opcode_o, d_source_o);
    end
    wait_drain("single_put");
    get_req(3'd3, 4'd6, BASE + 64'h40);
    checks++;
    if (d_valid_o !== 1'b0 || sram_req_o !== 1'b1 || sram_we_o !== 1'b0 || sram_addr_o !== 12'd8) begin
      errors++;
      $display("FAIL single_rd_req: d_valid=%0b req=%0b we=%0b addr=%0d, required 0 1 0 8", d_valid_o, sram_req_o, sram_we_o, sram_addr_o);
    end
    @(posedge clk_i); #1;
    checks++;
    if (d_valid_o !== 1'b1 || d_opcode_o !== 3'd1 || d_data_o !== 64'hDEADBEEF_01234567) begin
      errors++;
      $display("FAIL single_rd_data: d_valid=%0b op=%0d data=%h at T+2, required 1 1 deadbeef01234567", d_valid_o, d_opcode_o, d_data_o);
    end
    wait_drain("single_get");
  endtask

  task automatic test_burst();
    int c0;
    c0 = sram_req_cnt;
    put_req(3'd0, 3'd6, 4'd2, BASE + 64'h80, 8'hFF, 64'd0, 64'd1);
    wait_drain("burst_put");
    checks++;
    if (sram_req_cnt - c0 !== 8) begin
      errors++;
      $display("FAIL burst_write_count: got %0d SRAM writes, required 8", sram_req_cnt - c0);
    end
    c0 = sram_req_cnt;
    get_req(3'd6, 4'd3, BASE + 64'h80);
    wait_drain("burst_get");
    checks++;
    if (sram_req_cnt - c0 !== 8) begin
      errors++;
      $display("FAIL burst_read_count: got %0d SRAM reads, required 8", sram_req_cnt - c0);
    end
  endtask

  task automatic test_partial();
    put_req(3'd0, 3'd3, 4'd1, BASE + 64'h140, 8'hFF, 64'd0, 64'd0);
    wait_drain("partial_clear");
    put_req(3'd1, 3'd3, 4'd1, BASE + 64'h140, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    wait_drain("partial_put");
    get_req(3'd3, 4'd1, BASE + 64'h140);
    @(posedge clk_i); #1;
    checks++;
    if (d_data_o !== 64'h0000_0000_FFFF_FFFF) begin
      errors++;
      $display("FAIL partial_readback: got %h, required 00000000ffffffff", d_data_o);
    end
    wait_drain("partial_get");
  endtask

  task automatic test_deny();
    int c0;
    put_req(3'd0, 3'd6, 4'd9, BASE + 64'h8000 - 64'h40, 8'hFF, 64'h5000, 64'd1);
    wait_drain("deny_top_put");
    get_req(3'd6, 4'd9, BASE + 64'h8000 - 64'h40);
    wait_drain("deny_top_get");
    c0 = sram_req_cnt;
    get_req(3'd6, 4'd1, BASE + 64'h8000);
    wait_drain("deny_get_range");
    get_req(3'd3, 4'd2, BASE - 64'd8);
    wait_drain("deny_get_below");
    get_req(3'd7, 4'd3, BASE);
    wait_drain("deny_get_size");
    put_req(3'd0, 3'd3, 4'd4, BASE + 64'h8000, 8'hFF, 64'h1234, 64'd0);
    wait_drain("deny_put_range");
    put_req(3'd2, 3'd3, 4'd7, BASE + 64'h40, 8'hFF, 64'h9999, 64'd0);
    wait_drain("deny_opcode");
    checks++;
    if (sram_req_cnt !== c0) begin
      errors++;
      $display("FAIL deny_no_sram: got %0d SRAM accesses, required 0", sram_req_cnt - c0);
    end
    get_req(3'd3, 4'd6, BASE + 64'h40);
    wait_drain("deny_check_word");
  endtask

  task automatic test_backpressure();
    int seen = 0;
    bit stalled = 0;
    logic [76:0] snap;
    get_req(3'd6, 4'd8, BASE + 64'h80);
    for (int c = 0; c < 80 && seen < 8; c++) begin
      @(posedge clk_i); #1;
      if (d_valid_o) begin
        if (seen == 3 && !stalled) begin
          stalled = 1;
          d_ready_i = 1'b0;
          snap = {d_valid_o, d_opcode_o, d_denied_o, d_corrupt_o, d_data_o, d_size_o, d_source_o};
          checks++;
          if (d_data_o !== 64'd3) begin
            errors++;
            $display("FAIL bp_beat3_data: got %h, required 3", d_data_o);
          end
          repeat (5) begin
            @(posedge clk_i); #1;
            checks++;
            if ({d_valid_o, d_opcode_o, d_denied_o, d_corrupt_o, d_data_o, d_size_o, d_source_o} !== snap || sram_req_o !== 1'b0) begin
              errors++;
              $display("FAIL bp_stable: got fields=%h sram_req=%0b, required %h and 0",
                       {d_valid_o, d_opcode_o, d_denied_o, d_corrupt_o, d_data_o, d_size_o, d_source_o}, sram_req_o, snap);
            end
          end
          d_ready_i = 1'b1;
        end
        seen++;
      end
    end
    wait_drain("backpressure");
  endtask

  task automatic test_reset_mid();
    put_req(3'd0, 3'd6, 4'd4, BASE + 64'h200, 8'hFF, 64'hA00, 64'd1);
    wait_drain("rst_old_put");
    for (int k = 0; k < 4; k++) begin
      ref_mem[64 + k] = 64'h100 + 64'(k);
      a_send(3'd0, 3'd6, 4'd4, BASE + 64'h200, 8'hFF, 64'h100 + 64'(k));
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (a_ready_o !== 1'b0 || d_valid_o !== 1'b0 || sram_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: a_ready=%0b d_valid=%0b sram_req=%0b, required 0 0 0", a_ready_o, d_valid_o, sram_req_o);
    end
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (a_ready_o !== 1'b1 || d_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_idle: a_ready=%0b d_valid=%0b, required 1 0", a_ready_o, d_valid_o);
    end
    get_req(3'd6, 4'd4, BASE + 64'h200);
    wait_drain("rst_mid_get");
  endtask

  task automatic test_back_to_back();
    put_req(3'd0, 3'd3, 4'd11, BASE + 64'h300, 8'hFF, 64'h77, 64'd0);
    get_req(3'd3, 4'd12, BASE + 64'h300);
    checks++;
    if (last_wait !== 1) begin
      errors++;
      $display("FAIL b2b_idle_reentry: Get waited %0d cycles for a_ready_o, required 1", last_wait);
    end
    wait_drain("back_to_back");
  endtask

  initial begin
    rst_i = 1'b1; a_valid_i = 1'b0; d_ready_i = 1'b1;
    a_opcode_i = '0; a_param_i = '0; a_size_i = '0; a_source_i = '0;
    a_address_i = '0; a_mask_i = '0; a_data_i = '0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 64'd0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_burst();
    test_partial();
    test_deny();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
